// File: rtl/labs_pkg.sv
// rtl/labs_pkg.sv - shared types and constants for the LABS search controller
package labs_pkg;

   localparam int SEQ_WIDTH_DEF = 8;
   localparam int E_WIDTH_DEF   = 20;

   // Slice to E_WIDTH at the point of use; energies are assumed to be at most 32 bits.
   localparam logic [31:0] E_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/labs_search_ctrl_if.sv
// rtl/labs_search_ctrl_if.sv - host and datapath signals of the LABS search controller
interface labs_search_ctrl_if #(
   parameter int SEQ_WIDTH = labs_pkg::SEQ_WIDTH_DEF,
   parameter int E_WIDTH   = labs_pkg::E_WIDTH_DEF,
   parameter int CNT_WIDTH = SEQ_WIDTH + 1
);
   logic                 i_start;
   logic                 i_abort;
   logic [SEQ_WIDTH-1:0] i_base;
   logic [CNT_WIDTH-1:0] i_count;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_aborted;
   logic [SEQ_WIDTH-1:0] o_best_seq;
   logic [E_WIDTH-1:0]   o_best_e;
   logic [CNT_WIDTH-1:0] o_best_cnt;
   logic [CNT_WIDTH-1:0] o_result_cnt;
   logic [SEQ_WIDTH-1:0] o_pipe_seq;
   logic                 o_pipe_valid;
   logic [SEQ_WIDTH-1:0] i_pipe_seq;
   logic [E_WIDTH-1:0]   i_pipe_e;
   logic                 i_pipe_valid;

   modport master (
      output i_start, i_abort, i_base, i_count, i_pipe_seq, i_pipe_e, i_pipe_valid,
      input  o_busy, o_done, o_aborted, o_best_seq, o_best_e, o_best_cnt, o_result_cnt,
      input  o_pipe_seq, o_pipe_valid
   );

   modport slave (
      input  i_start, i_abort, i_base, i_count, i_pipe_seq, i_pipe_e, i_pipe_valid,
      output o_busy, o_done, o_aborted, o_best_seq, o_best_e, o_best_cnt, o_result_cnt,
      output o_pipe_seq, o_pipe_valid
   );

endinterface

// File: rtl/labs_best_tracker.sv
// rtl/labs_best_tracker.sv - running minimum energy, its first sequence, tie and result counts
module labs_best_tracker
   import labs_pkg::*;
#(
   parameter int SEQ_WIDTH = SEQ_WIDTH_DEF,
   parameter int E_WIDTH   = E_WIDTH_DEF,
   parameter int CNT_WIDTH = SEQ_WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 valid_i,
   input  logic [SEQ_WIDTH-1:0] seq_i,
   input  logic [E_WIDTH-1:0]   e_i,
   output logic [SEQ_WIDTH-1:0] best_seq_o,
   output logic [E_WIDTH-1:0]   best_e_o,
   output logic [CNT_WIDTH-1:0] best_cnt_o,
   output logic [CNT_WIDTH-1:0] result_cnt_o
);

   logic [SEQ_WIDTH-1:0] best_seq_q, best_seq_d;
   logic [E_WIDTH-1:0]   best_e_q, best_e_d;
   logic [CNT_WIDTH-1:0] best_cnt_q, best_cnt_d;
   logic [CNT_WIDTH-1:0] result_cnt_q, result_cnt_d;

   always_comb begin
      best_seq_d   = best_seq_q;
      best_e_d     = best_e_q;
      best_cnt_d   = best_cnt_q;
      result_cnt_d = result_cnt_q;
      if (clr_i) begin
         best_seq_d   = '0;
         best_e_d     = E_MAX[E_WIDTH-1:0];
         best_cnt_d   = '0;
         result_cnt_d = '0;
      end else if (valid_i) begin
         result_cnt_d = result_cnt_q + CNT_WIDTH'(1);
         // Ties keep the earliest sequence; only a strictly lower energy replaces it.
         if (e_i < best_e_q) begin
            best_seq_d = seq_i;
            best_e_d   = e_i;
            best_cnt_d = CNT_WIDTH'(1);
         end else if (e_i == best_e_q) begin
            best_cnt_d = best_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         best_seq_q   <= '0;
         best_e_q     <= E_MAX[E_WIDTH-1:0];
         best_cnt_q   <= '0;
         result_cnt_q <= '0;
      end else begin
         best_seq_q   <= best_seq_d;
         best_e_q     <= best_e_d;
         best_cnt_q   <= best_cnt_d;
         result_cnt_q <= result_cnt_d;
      end
   end

   assign best_seq_o   = best_seq_q;
   assign best_e_o     = best_e_q;
   assign best_cnt_o   = best_cnt_q;
   assign result_cnt_o = result_cnt_q;

endmodule

// File: rtl/labs_search_ctrl.sv
// rtl/labs_search_ctrl.sv - issues a contiguous candidate range into calc_e and drains its results
module labs_search_ctrl
   import labs_pkg::*;
#(
   parameter int SEQ_WIDTH = SEQ_WIDTH_DEF,
   parameter int E_WIDTH   = E_WIDTH_DEF,
   parameter int CNT_WIDTH = SEQ_WIDTH + 1
) (
   input logic               clk,
   input logic               rst,
   labs_search_ctrl_if.slave bus
);

   state_e               state_q, state_d;
   logic [SEQ_WIDTH-1:0] base_q, base_d;
   logic [SEQ_WIDTH-1:0] pseq_q, pseq_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] issued_q, issued_d;
   logic [CNT_WIDTH-1:0] inflight_q, inflight_d;
   logic                 pvalid_q, pvalid_d;
   logic                 aborted_q, aborted_d;
   logic                 busy, start_ok, ret;

   assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign start_ok = bus.i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign ret      = bus.i_pipe_valid && busy;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      pseq_d     = pseq_q;
      count_d    = count_q;
      issued_d   = issued_q;
      aborted_d  = aborted_q;
      pvalid_d   = 1'b0;
      // The candidate currently on o_pipe_valid is the issue counted this cycle.
      inflight_d = inflight_q + CNT_WIDTH'(pvalid_q) - CNT_WIDTH'(ret);
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               base_d    = bus.i_base;
               count_d   = bus.i_count;
               aborted_d = 1'b0;
               issued_d  = '0;
               if (bus.i_count != '0) begin
                  state_d  = ST_RUN;
                  pvalid_d = 1'b1;
                  pseq_d   = bus.i_base;
                  issued_d = CNT_WIDTH'(1);
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (bus.i_abort) begin
               aborted_d = 1'b1;
               state_d   = ST_DRAIN;
            end else if (issued_q == count_q) begin
               state_d = ST_DRAIN;
            end else begin
               pvalid_d = 1'b1;
               pseq_d   = base_q + issued_q[SEQ_WIDTH-1:0];
               issued_d = issued_q + CNT_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            if (bus.i_abort) begin
               aborted_d = 1'b1;
            end
            if (inflight_d == '0) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         pseq_q     <= '0;
         count_q    <= '0;
         issued_q   <= '0;
         inflight_q <= '0;
         pvalid_q   <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         pseq_q     <= pseq_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         inflight_q <= inflight_d;
         pvalid_q   <= pvalid_d;
         aborted_q  <= aborted_d;
      end
   end

   labs_best_tracker #(
      .SEQ_WIDTH (SEQ_WIDTH),
      .E_WIDTH   (E_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_best (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (start_ok),
      .valid_i      (ret),
      .seq_i        (bus.i_pipe_seq),
      .e_i          (bus.i_pipe_e),
      .best_seq_o   (bus.o_best_seq),
      .best_e_o     (bus.o_best_e),
      .best_cnt_o   (bus.o_best_cnt),
      .result_cnt_o (bus.o_result_cnt)
   );

   assign bus.o_busy       = busy;
   assign bus.o_done       = (state_q == ST_DONE);
   assign bus.o_aborted    = aborted_q;
   assign bus.o_pipe_seq   = pseq_q;
   assign bus.o_pipe_valid = pvalid_q;

endmodule

// File: tb/tb_labs_search_ctrl.sv
// tb/tb_labs_search_ctrl.sv - self-checking bench for labs_search_ctrl with a behavioural calc_e
module tb_labs_search_ctrl;

   localparam int SW  = 8;
   localparam int EW  = 20;
   localparam int CW  = 9;
   localparam int LAT = SW + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   labs_search_ctrl_if #(.SEQ_WIDTH(SW), .E_WIDTH(EW), .CNT_WIDTH(CW)) bus();

   labs_search_ctrl #(.SEQ_WIDTH(SW), .E_WIDTH(EW), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Energy of a +/-1 sequence: sum over shifts k of the squared aperiodic autocorrelation.
   function automatic int labs_e(input logic [7:0] s);
      int e = 0;
      for (int k = 1; k < 8; k++) begin
         int c = 0;
         for (int i = 0; i < 8 - k; i++) c += (s[i] == s[i+k]) ? 1 : -1;
         e += c * c;
      end
      return e;
   endfunction

   int mode = 0;
   int e_tab[256];
   int push_idx = 0;
   int returned = 0;
   int pv_runs = 0;
   logic pv_prev = 1'b0;
   logic [7:0] log_seq[$];

   function automatic int cand_e(input int m, input int idx, input logic [7:0] s);
      return (m == 0) ? labs_e(s) : e_tab[idx];
   endfunction

   typedef struct {
      logic        v;
      logic [7:0]  s;
      logic [19:0] e;
   } pkt_t;
   pkt_t pipe_q[$];

   // Fixed-latency datapath model: a candidate seen in one cycle returns LAT cycles later.
   initial begin : pipe_model
      pkt_t p;
      for (int i = 0; i < LAT; i++) pipe_q.push_back('{1'b0, 8'h00, 20'h0});
      bus.i_pipe_valid = 1'b0;
      bus.i_pipe_seq   = '0;
      bus.i_pipe_e     = '0;
      forever begin
         @(negedge clk);
         p.v = bus.o_pipe_valid;
         p.s = bus.o_pipe_seq;
         p.e = '0;
         if (p.v === 1'b1) begin
            p.e = 20'(cand_e(mode, push_idx, p.s));
            push_idx++;
            log_seq.push_back(p.s);
            if (!pv_prev) pv_runs++;
         end
         pv_prev = (p.v === 1'b1);
         pipe_q.push_back(p);
         p = pipe_q.pop_front();
         bus.i_pipe_valid = p.v;
         bus.i_pipe_seq   = p.s;
         bus.i_pipe_e     = p.e;
         if (p.v) returned++;
      end
   end

   typedef struct {
      string name;
      int    base;
      int    cnt;
      int    mode;
      int    abort_at;
      int    ign_at;
      int    exp_res;
      int    exp_e;
      int    exp_cnt;
      int    exp_seq;
   } vec_t;

   task automatic check_reset(input string tag);
      check({tag, " busy"}, bus.o_busy, 0);
      check({tag, " done"}, bus.o_done, 0);
      check({tag, " aborted"}, bus.o_aborted, 0);
      check({tag, " best_seq"}, bus.o_best_seq, 0);
      check({tag, " best_e"}, bus.o_best_e, 64'hFFFFF);
      check({tag, " best_cnt"}, bus.o_best_cnt, 0);
      check({tag, " result_cnt"}, bus.o_result_cnt, 0);
      check({tag, " pipe_seq"}, bus.o_pipe_seq, 0);
      check({tag, " pipe_valid"}, bus.o_pipe_valid, 0);
   endtask

   // Call at a negedge; returns at a negedge with the DUT in DONE (or after the cycle budget).
   task automatic run_search(input vec_t v);
      int n_exp, cyc, issued, b_e, b_cnt, b_seq, e, mism;
      bit ab;
      logic [7:0] s;
      if (v.mode == 1) begin
         e_tab[0] = 5; e_tab[1] = 3; e_tab[2] = 3; e_tab[3] = 7;
      end else if (v.mode == 2) begin
         for (int i = 0; i < 256; i++) e_tab[i] = $urandom_range(0, 7);
      end
      mode  = v.mode;
      n_exp = (v.abort_at > 0 && v.abort_at < v.cnt) ? v.abort_at : v.cnt;
      ab    = (v.abort_at > 0 && v.cnt > 0);
      b_e = 'hFFFFF; b_cnt = 0; b_seq = 0;
      for (int i = 0; i < n_exp; i++) begin
         s = 8'(v.base + i);
         e = cand_e(v.mode, i, s);
         if (e < b_e) begin b_e = e; b_cnt = 1; b_seq = int'(s); end
         else if (e == b_e) b_cnt++;
      end
      log_seq.delete();
      push_idx = 0; returned = 0; pv_runs = 0;
      bus.i_base  = 8'(v.base);
      bus.i_count = 9'(v.cnt);
      bus.i_start = 1'b1;
      @(negedge clk);
      cyc = 1; issued = 0;
      forever begin
         bus.i_start = 1'b0;
         bus.i_abort = 1'b0;
         if (bus.o_pipe_valid) issued++;
         if (v.abort_at > 0 && bus.o_pipe_valid && issued == v.abort_at) bus.i_abort = 1'b1;
         if (v.ign_at > 0 && bus.o_pipe_valid && issued == v.ign_at) begin
            bus.i_start = 1'b1; bus.i_base = 8'h99; bus.i_count = 9'd50;
         end
         if (bus.o_done || cyc >= 3000) break;
         @(negedge clk);
         cyc++;
      end
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
      mism = 0;
      foreach (log_seq[i]) if (log_seq[i] !== 8'(v.base + i)) mism++;
      check({v.name, " done"}, bus.o_done, 1);
      check({v.name, " busy"}, bus.o_busy, 0);
      check({v.name, " aborted"}, bus.o_aborted, ab);
      check({v.name, " result_cnt"}, bus.o_result_cnt, n_exp);
      check({v.name, " best_e"}, bus.o_best_e, b_e);
      check({v.name, " best_cnt"}, bus.o_best_cnt, b_cnt);
      check({v.name, " best_seq"}, bus.o_best_seq, b_seq);
      check({v.name, " drained"}, returned, n_exp);
      check({v.name, " issue_count"}, log_seq.size(), n_exp);
      check({v.name, " issue_seq_mismatches"}, mism, 0);
      check({v.name, " valid_runs"}, pv_runs, (n_exp > 0) ? 1 : 0);
      if (v.cnt == 0) check({v.name, " done_cycle"}, cyc, 1);
      else if (!ab) check({v.name, " done_latency_window"}, (cyc >= v.cnt + LAT && cyc <= v.cnt + LAT + 3), 1);
      if (v.exp_res >= 0) check({v.name, " result_cnt_const"}, bus.o_result_cnt, v.exp_res);
      if (v.exp_e >= 0)   check({v.name, " best_e_const"}, bus.o_best_e, v.exp_e);
      if (v.exp_cnt >= 0) check({v.name, " best_cnt_const"}, bus.o_best_cnt, v.exp_cnt);
      if (v.exp_seq >= 0) check({v.name, " best_seq_const"}, bus.o_best_seq, v.exp_seq);
   endtask

   initial begin : main
      vec_t vecs[6];
      vec_t rv;
      int   w;
      vecs[0] = '{"full",       0,     256, 0, 0,  0, 256, 8,       -1, -1};
      vecs[1] = '{"wrap",       'hFE,  4,   0, 0,  0, 4,   -1,      -1, -1};
      vecs[2] = '{"zero",       0,     0,   0, 0,  0, 0,   'hFFFFF, 0,  -1};
      vecs[3] = '{"abort",      0,     200, 0, 10, 0, 10,  -1,      -1, -1};
      vecs[4] = '{"ties",       'h40,  4,   1, 0,  2, 4,   3,       2,  'h41};
      vecs[5] = '{"abort_last", 'h10,  5,   0, 5,  0, 5,   -1,      -1, -1};

      bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_base = '0; bus.i_count = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_search(vecs[i]);

      // Reset while draining: everything clears and late returns are ignored.
      mode = 0; push_idx = 0;
      bus.i_base = 8'h00; bus.i_count = 9'd20; bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      w = 0;
      while (!(bus.o_busy && !bus.o_pipe_valid) && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("rst_drain reached_drain", w < 200, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset("rst_drain");
      rst = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      check("rst_drain late result_cnt", bus.o_result_cnt, 0);
      check("rst_drain late busy", bus.o_busy, 0);
      check("rst_drain late done", bus.o_done, 0);
      check("rst_drain late best_e", bus.o_best_e, 64'hFFFFF);

      for (int r = 0; r < 10; r++) begin
         rv.name     = $sformatf("rand%0d", r);
         rv.base     = $urandom_range(0, 255);
         rv.cnt      = $urandom_range(0, 40);
         rv.mode     = 2;
         rv.abort_at = ($urandom_range(0, 2) == 0 && rv.cnt > 0) ? $urandom_range(1, rv.cnt) : 0;
         rv.ign_at   = 0;
         rv.exp_res  = -1; rv.exp_e = -1; rv.exp_cnt = -1; rv.exp_seq = -1;
         run_search(rv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/labs_search_ctrl.md
Name: labs_search_ctrl

Overview:
Search scheduler for the pipelined sidelobe-energy datapath (calc_e). It enumerates a contiguous range of candidate binary sequences and issues one candidate per cycle into the energy pipeline. It collects the returning (sequence, energy) results and keeps the minimum energy, its sequence, and how many candidates hit it. The block sits between the host/Wishbone register bank and one calc_e instance. It owns start/abort/done sequencing.

Parameters:
SEQ_WIDTH, 8, candidate sequence length in bits; must match the datapath
E_WIDTH, 20, energy result width; must match the datapath
CNT_WIDTH, SEQ_WIDTH+1, width of the candidate count, enough to hold 2^SEQ_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_start  in  1  single-cycle start request
i_abort  in  1  single-cycle abort request
i_base  in  SEQ_WIDTH  first candidate sequence, sampled on accepted start
i_count  in  CNT_WIDTH  number of candidates, sampled on accepted start
o_busy  out  1  high in RUN or DRAIN
o_done  out  1  high in DONE (level; cleared by next accepted start)
o_aborted  out  1  last search ended by abort
o_best_seq  out  SEQ_WIDTH  sequence with the minimum energy
o_best_e  out  E_WIDTH  minimum energy found; all-ones if no result yet
o_best_cnt  out  CNT_WIDTH  number of results equal to o_best_e
o_result_cnt  out  CNT_WIDTH  results received this search
o_pipe_seq  out  SEQ_WIDTH  candidate to datapath (registered)
o_pipe_valid  out  1  candidate valid (registered)
i_pipe_seq  in  SEQ_WIDTH  returned sequence
i_pipe_e  in  E_WIDTH  returned energy
i_pipe_valid  in  1  returned result valid

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port rst.
- While rst is high, at the next clk edge:
  - state=IDLE;
  - o_pipe_valid, o_busy, o_done, o_aborted = 0;
  - o_best_seq, o_pipe_seq = 0; o_best_cnt, o_result_cnt = 0; o_best_e = all-ones;
  - issue counter and in-flight counter = 0.
  - Reset mid-search drops everything. Results returning after reset are ignored, because in-flight=0 and the state is IDLE.
- States: IDLE, RUN, DRAIN, DONE.
- Start:
  - Accepted only in IDLE or DONE; ignored in RUN and DRAIN.
  - On acceptance: latch base and count, clear best/result counters and o_aborted, set o_best_e = all-ones, o_done = 0.
  - Next state is RUN if count>0, else DONE.
- RUN:
  - Each cycle, drive o_pipe_valid=1 and o_pipe_seq = base + issued (mod 2^SEQ_WIDTH, wraps silently); then increment issued.
  - First candidate appears the cycle after the start edge.
  - After the count-th issue, the state goes to DRAIN. o_pipe_valid drops the following cycle, so exactly count candidates are issued back-to-back.
- Abort:
  - In RUN: no further issue (o_pipe_valid=0 from the next cycle), go to DRAIN, set o_aborted=1.
  - In DRAIN: sets o_aborted only.
  - Ignored in IDLE/DONE.
  - Abort and the final issue in the same cycle: that candidate is still issued; o_aborted=1.
- In-flight counter:
  - Increments on each issue and decrements on each i_pipe_valid.
  - Simultaneous issue and return leaves it unchanged.
  - The datapath has no backpressure; the controller never stalls.
- DRAIN: when in-flight==0 (including the same-cycle decrement), go to DONE.
- Result update on i_pipe_valid while in RUN/DRAIN:
  - o_result_cnt increments.
  - If i_pipe_e < o_best_e: replace best_seq/best_e and set best_cnt=1.
  - Else if equal: best_cnt increments, and best_seq keeps the earliest result.
  - i_pipe_valid in IDLE/DONE is ignored.
- o_done=1 and o_busy=0 in DONE; the result outputs hold until the next accepted start.
- Latency: done rises about count + pipeline latency (SEQ_WIDTH+1) + 2 cycles after start.

Decomposition:
- Package labs_pkg:
  - state enum typedef (IDLE/RUN/DRAIN/DONE);
  - localparams for default SEQ_WIDTH/E_WIDTH;
  - E_MAX all-ones constant.
- One sub-module, labs_best_tracker: min-compare, best_seq/best_e/best_cnt/result_cnt registers, with a clear input.
- Issue/drain FSM and counters stay in the top.

Test Plan:
- Full space, SEQ_WIDTH=8, real calc_e attached: base=0, count=256.
  - o_pipe_valid high for exactly 256 consecutive cycles.
  - o_result_cnt=256, o_best_e=8.
  - o_best_seq and o_best_cnt match the bench reference model (first minimum in issue order).
- Wrap: base=0xFE, count=4 -> issued sequence 0xFE, 0xFF, 0x00, 0x01; o_result_cnt=4.
- Zero count: start with count=0 -> DONE next cycle, o_pipe_valid never high, o_best_e=0xFFFFF, o_best_cnt=0.
- Abort: base=0, count=200, abort on 10th issue cycle.
  - 10 candidates issued; o_result_cnt=10 at done.
  - o_aborted=1; done only after the last result drains.
- Ties and ignored start, using a stub pipeline returning energies 5, 3, 3, 7:
  - o_best_e=3, o_best_cnt=2, o_best_seq = second candidate.
  - A start pulsed in RUN is ignored.
- Reset mid-DRAIN: all outputs return to reset values next cycle; late i_pipe_valid pulses leave o_result_cnt=0.
